// File: rtl/xbar_router_pkg.sv
// Shared types and default sizing for the PE-to-accumulate-buffer crossbar.
// DATA_PACKET is the unit carried from a PE source FIFO to a destination port.
package xbar_router_pkg;

  localparam int NUM_SRC_DEFAULT    = 4;
  localparam int NUM_DST_DEFAULT    = 4;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  localparam int INDEX_W = 8;
  localparam int DATA_W  = 16;

  typedef struct packed {
    logic               valid;
    logic [INDEX_W-1:0] index;
    logic [DATA_W-1:0]  data;
  } DATA_PACKET;

endpackage

// File: rtl/xbar_src_fifo.sv
// Per-source packet FIFO with wrap-bit pointers and a sticky overflow flag.
// A pop in the same cycle never makes room for a push; full is judged on current pointers.
module xbar_src_fifo
  import xbar_router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  DATA_PACKET push_packet,
  output logic       in_ready,
  input  logic       pop,
  output DATA_PACKET head,
  output logic       empty,
  output logic       overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wt_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           full;
  logic           push;
  DATA_PACKET     mem [DEPTH];

  assign full     = (wt_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wt_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign empty    = (wt_ptr == rd_ptr);
  assign in_ready = !full;
  assign push     = push_packet.valid && !full;
  assign head     = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wt_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wt_ptr <= wt_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (push_packet.valid && full) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push) mem[wt_ptr[PTR_W-1:0]] <= push_packet;
  end

endmodule

// File: rtl/xbar_router.sv
// Source-FIFO crossbar: each FIFO head requests one destination, and every destination
// picks a requester round-robin into a registered output slot with ready backpressure.
module xbar_router
  import xbar_router_pkg::*;
#(
  parameter int NUM_SRC    = NUM_SRC_DEFAULT,
  parameter int NUM_DST    = NUM_DST_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  DATA_PACKET         in_packet [NUM_SRC],
  output logic [NUM_SRC-1:0] in_ready,
  output DATA_PACKET         out_packet [NUM_DST],
  output logic [NUM_DST-1:0] out_valid,
  input  logic [NUM_DST-1:0] out_ready,
  output logic               busy,
  output logic [NUM_SRC-1:0] overflow
);

  localparam int DST_SEL_W = $clog2(NUM_DST);
  localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  DATA_PACKET         head [NUM_SRC];
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] req [NUM_DST];
  logic [NUM_DST-1:0] grant;
  logic [SRC_W-1:0]   grant_src [NUM_DST];
  logic [SRC_W-1:0]   rr_ptr [NUM_DST];
  logic [SRC_W-1:0]   cand;

  function automatic logic [SRC_W-1:0] wrap_src(input int v);
    return SRC_W'(v % NUM_SRC);
  endfunction

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    xbar_src_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_packet(in_packet[s]),
      .in_ready   (in_ready[s]),
      .pop        (pop[s]),
      .head       (head[s]),
      .empty      (empty[s]),
      .overflow   (overflow[s])
    );
  end

  // Each source asks for exactly one destination, so each source pops at most once per cycle.
  always_comb begin
    pop   = '0;
    grant = '0;
    cand  = '0;
    for (int d = 0; d < NUM_DST; d++) begin
      req[d]       = '0;
      grant_src[d] = '0;
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      if (!empty[s]) req[head[s].index[DST_SEL_W-1:0]][s] = 1'b1;
    end
    for (int d = 0; d < NUM_DST; d++) begin
      if (!out_valid[d] || out_ready[d]) begin
        for (int k = 0; k < NUM_SRC; k++) begin
          cand = wrap_src(int'(rr_ptr[d]) + k);
          if (!grant[d] && req[d][cand]) begin
            grant[d]     = 1'b1;
            grant_src[d] = cand;
          end
        end
      end
    end
    for (int d = 0; d < NUM_DST; d++) begin
      if (grant[d]) pop[grant_src[d]] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= '0;
      for (int d = 0; d < NUM_DST; d++) begin
        out_packet[d] <= '0;
        rr_ptr[d]     <= '0;
      end
    end else begin
      for (int d = 0; d < NUM_DST; d++) begin
        if (grant[d]) begin
          out_packet[d]       <= head[grant_src[d]];
          out_packet[d].valid <= 1'b1;
          out_valid[d]        <= 1'b1;
          rr_ptr[d]           <= wrap_src(int'(grant_src[d]) + 1);
        end else if (out_ready[d]) begin
          out_valid[d]        <= 1'b0;
          out_packet[d].valid <= 1'b0;
        end
      end
    end
  end

  assign busy = (|(~empty)) | (|out_valid);

endmodule

// File: tb/tb_xbar_router.sv
// Scenario bench for xbar_router: expected packets are queued per destination as they are
// offered and matched against every consumed output; each task adds its own timing checks.
module tb_xbar_router;
  import xbar_router_pkg::*;

  localparam int NS = 4;
  localparam int ND = 4;
  localparam int FD = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  DATA_PACKET     in_packet [NS];
  logic [NS-1:0]  in_ready;
  DATA_PACKET     out_packet [ND];
  logic [ND-1:0]  out_valid;
  logic [ND-1:0]  out_ready;
  logic           busy;
  logic [NS-1:0]  overflow;

  int         vectors = 0;
  int         miscompares = 0;
  DATA_PACKET exp_q [ND][$];
  DATA_PACKET sb_exp;

  xbar_router #(
    .NUM_SRC   (NS),
    .NUM_DST   (ND),
    .FIFO_DEPTH(FD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_packet (in_packet),
    .in_ready  (in_ready),
    .out_packet(out_packet),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every consumed output must match the oldest packet expected at that port.
  always @(negedge clock) begin
    if (reset) begin
      for (int d = 0; d < ND; d++) begin
        if (out_valid[d] && out_ready[d]) begin
          vectors++;
          if (exp_q[d].size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected dst%0d got index=%0d data=%0d expected none",
                     d, out_packet[d].index, out_packet[d].data);
          end else begin
            sb_exp = exp_q[d].pop_front();
            if (out_packet[d] !== sb_exp) begin
              miscompares++;
              $display("FAIL sb_order dst%0d got %h expected %h", d, out_packet[d], sb_exp);
            end
          end
        end
      end
    end
  end

  function automatic DATA_PACKET mk(input int idx, input int dat);
    DATA_PACKET p;
    p.valid = 1'b1;
    p.index = INDEX_W'(idx);
    p.data  = DATA_W'(dat);
    return p;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < NS; s++) in_packet[s] = '0;
  endtask

  task automatic offer(input int s, input int idx, input int dat, input bit accept);
    in_packet[s] = mk(idx, dat);
    if (accept) exp_q[idx % ND].push_back(mk(idx, dat));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge clock);
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle busy=%b expected 0 after %0d cycles", name, busy, budget);
    end
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if (exp_q[d].size() != 0) begin
        miscompares++;
        $display("FAIL %s_leftover dst%0d still expects %0d packets, expected 0", name, d, exp_q[d].size());
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    out_ready = '1;
    reset = 1'b0;
    #12;
    vectors++;
    if (in_ready !== 4'b1111) begin miscompares++; $display("FAIL rst_in_ready got=%b expected 1111", in_ready); end
    vectors++;
    if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL rst_out_valid got=%b expected 0000", out_valid); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b expected 0", busy); end
    vectors++;
    if (overflow !== 4'b0000) begin miscompares++; $display("FAIL rst_overflow got=%b expected 0000", overflow); end
    vectors++;
    if (out_packet[2] !== '0) begin miscompares++; $display("FAIL rst_out_packet got=%h expected 0", out_packet[2]); end
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_single();
    step();
    offer(0, 6, 55, 1'b1);
    step();
    clear_inputs();
    @(negedge clock);
    vectors++;
    if (out_valid !== 4'b0000 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_pending out_valid=%b busy=%b expected 0000/1", out_valid, busy);
    end
    @(negedge clock);
    vectors++;
    if (out_valid !== 4'b0100) begin miscompares++; $display("FAIL single_valid got=%b expected 0100", out_valid); end
    vectors++;
    if (out_packet[2] !== mk(6, 55)) begin
      miscompares++;
      $display("FAIL single_packet got=%h expected %h", out_packet[2], mk(6, 55));
    end
    @(negedge clock);
    vectors++;
    if (out_valid !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain out_valid=%b busy=%b expected 0000/0", out_valid, busy);
    end
  endtask

  task automatic rr_burst(input int pass);
    step();
    for (int s = 0; s < NS; s++) offer(s, 1, 10 + s, 1'b1);
    step();
    clear_inputs();
    @(negedge clock);
    for (int i = 0; i < NS; i++) begin
      @(negedge clock);
      vectors++;
      if (out_valid[1] !== 1'b1 || out_packet[1].data !== DATA_W'(10 + i)) begin
        miscompares++;
        $display("FAIL rr_burst%0d_slot%0d valid=%b data=%0d expected 1/%0d",
                 pass, i, out_valid[1], out_packet[1].data, 10 + i);
      end
    end
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_burst%0d_busy got=%b expected 0", pass, busy); end
  endtask

  task automatic test_round_robin();
    rr_burst(0);
    rr_burst(1);
  endtask

  task automatic fill_src1(input bit check);
    out_ready = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      if (check) begin
        vectors++;
        if (in_ready[1] !== 1'b1) begin miscompares++; $display("FAIL bp_ready_early push%0d got=0 expected 1", i); end
      end
      offer(1, 3, 100 + i, 1'b1);
      step();
    end
    clear_inputs();
    @(negedge clock);
    if (check) begin
      vectors++;
      if (in_ready[1] !== 1'b0) begin miscompares++; $display("FAIL bp_full in_ready1 got=1 expected 0"); end
      vectors++;
      if (out_valid[3] !== 1'b1 || out_packet[3].data !== DATA_W'(100)) begin
        miscompares++;
        $display("FAIL bp_hold valid=%b data=%0d expected 1/100", out_valid[3], out_packet[3].data);
      end
      vectors++;
      if (overflow !== 4'b0000) begin miscompares++; $display("FAIL bp_no_ovf got=%b expected 0000", overflow); end
    end
    offer(1, 3, 105, 1'b0);
    @(posedge clock);
    #1 clear_inputs();
    @(negedge clock);
    vectors++;
    if (overflow !== 4'b0010) begin miscompares++; $display("FAIL bp_overflow got=%b expected 0010", overflow); end
  endtask

  task automatic test_backpressure();
    step();
    fill_src1(1'b1);
    @(posedge clock);
    #1 out_ready = '1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      vectors++;
      if (out_valid[3] !== 1'b1 || out_packet[3].data !== DATA_W'(100 + i)) begin
        miscompares++;
        $display("FAIL bp_drain%0d valid=%b data=%0d expected 1/%0d", i, out_valid[3], out_packet[3].data, 100 + i);
      end
    end
    @(negedge clock);
    vectors++;
    if (out_valid[3] !== 1'b0) begin miscompares++; $display("FAIL bp_extra valid=1 expected 0 after 5 packets"); end
    wait_idle("bp", 20);
  endtask

  task automatic test_stream();
    step();
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          vectors++;
          if (in_ready[2] !== 1'b1) begin miscompares++; $display("FAIL stream_ready%0d got=0 expected 1", k); end
          offer(2, 0, k, 1'b1);
          step();
        end
        clear_inputs();
      end
      begin
        repeat (2) @(negedge clock);
        for (int k = 0; k < 10; k++) begin
          @(negedge clock);
          vectors++;
          if (out_valid[0] !== 1'b1 || out_packet[0].data !== DATA_W'(k)) begin
            miscompares++;
            $display("FAIL stream_cycle%0d valid=%b data=%0d expected 1/%0d", k, out_valid[0], out_packet[0].data, k);
          end
        end
      end
    join
    wait_idle("stream", 20);
    vectors++;
    if (overflow[2] !== 1'b0) begin miscompares++; $display("FAIL stream_overflow got=1 expected 0"); end
  endtask

  task automatic test_parallel();
    step();
    for (int s = 0; s < NS; s++) offer(s, s, 200 + s, 1'b1);
    step();
    clear_inputs();
    @(negedge clock);
    vectors++;
    if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL par_early got=%b expected 0000", out_valid); end
    @(negedge clock);
    vectors++;
    if (out_valid !== 4'b1111) begin miscompares++; $display("FAIL par_valid got=%b expected 1111", out_valid); end
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if (out_packet[d] !== mk(d, 200 + d)) begin
        miscompares++;
        $display("FAIL par_data dst%0d got=%h expected %h", d, out_packet[d], mk(d, 200 + d));
      end
    end
    wait_idle("par", 20);
  endtask

  task automatic test_async_reset();
    step();
    fill_src1(1'b0);
    @(posedge clock);
    #3 reset = 1'b0;
    for (int d = 0; d < ND; d++) exp_q[d].delete();
    #1;
    vectors++;
    if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL arst_out_valid got=%b expected 0000", out_valid); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy got=%b expected 0", busy); end
    vectors++;
    if (overflow !== 4'b0000) begin miscompares++; $display("FAIL arst_overflow got=%b expected 0000", overflow); end
    vectors++;
    if (in_ready !== 4'b1111) begin miscompares++; $display("FAIL arst_in_ready got=%b expected 1111", in_ready); end
    @(posedge clock);
    #1 reset = 1'b1;
    out_ready = '1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      vectors++;
      if (out_valid !== 4'b0000 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL arst_stale cycle%0d out_valid=%b busy=%b expected 0000/0", i, out_valid, busy);
      end
    end
  endtask

  initial begin
    clear_inputs();
    out_ready = '1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stream();
    test_parallel();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
